// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared constants and types for the RGB444 -> grayscale pipeline controller.
//   * Luma weights in 6-bit fixed point (value / 64): R=14, G=46, B=5.
//   * Rounding constant added before the /64 truncation (half an LSB).
//   * Controller FSM state encoding.
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam logic [5:0]  W_R     = 6'd14;
    localparam logic [5:0]  W_G     = 6'd46;
    localparam logic [5:0]  W_B     = 6'd5;
    localparam logic [11:0] ROUND_C = 12'd32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One valid/ready register slice of parameterised width. The slice loads
// whenever it is empty or its content is being taken downstream, so a full
// pipeline of these sustains one item per cycle and stalls without loss.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and payload
// -----------------------------------------------------------------------------
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         advance;

    assign advance     = !valid_q || out_ready_i;
    assign in_ready_o  = advance;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (advance) begin
            valid_q <= in_valid_i;
            // Keep the old payload on bubbles; it is never observed anyway.
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/gray_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// gray_pipe_ctrl
// Frame controller for a two-stage RGB444 grayscale / pass-through pipeline.
// A start pulse in IDLE latches the mode and opens the input for PIX_COUNT
// pixels; the last one is tagged and the frame completes when it leaves the
// output, producing a one-cycle done pulse.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, gray_en              frame start pulse and mode (1 = grayscale)
//   in_valid/in_ready/in_rgb    input pixel stream {r,g,b} 4 bits each
//   out_valid/out_ready/out_rgb/out_last  output stream, last pixel marked
//   busy, done                  not-idle flag, frame completion pulse
// -----------------------------------------------------------------------------
module gray_pipe_ctrl
    import gray_pkg::*;
#(
    parameter int PIX_COUNT = 76800,
    parameter int CNT_W     = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        gray_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_rgb,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_COUNT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             mode_q,  mode_d;
    logic             done_q,  done_d;

    // Stage-1 interface
    logic        s1_in_valid, s1_ready, s1_valid;
    logic        in_fire, in_is_last;
    logic [11:0] m1_d, m2_d, m3_d;
    logic [36:0] s1_in_data, s1_data;
    logic [11:0] s1_m1, s1_m2, s1_m3;
    logic        s1_last;

    // Stage-2 interface
    logic        s2_ready;
    logic [11:0] sum_d;
    logic [3:0]  gray_d;
    logic [11:0] res_d;
    logic [12:0] s2_in_data, s2_data;
    logic        out_fire;

    // ---------------------------------------------------------------- input
    // Pixels enter only while running; IDLE/DRAIN traffic never reaches stage 1.
    assign s1_in_valid = in_valid && (state_q == ST_RUN);
    assign in_ready    = (state_q == ST_RUN) && s1_ready;
    assign in_fire     = in_valid && in_ready;
    assign in_is_last  = (cnt_q == LAST_IDX);

    // Products for grayscale; in pass-through the raw pixel rides in m1 and
    // the other two lanes are zero, so stage 2 can simply select m1.
    always_comb begin
        if (mode_q) begin
            m1_d = {8'h00, in_rgb[11:8]} * {6'h00, W_R};
            m2_d = {8'h00, in_rgb[7:4]}  * {6'h00, W_G};
            m3_d = {8'h00, in_rgb[3:0]}  * {6'h00, W_B};
        end else begin
            m1_d = in_rgb;
            m2_d = 12'h000;
            m3_d = 12'h000;
        end
    end

    assign s1_in_data = {m1_d, m2_d, m3_d, in_is_last};

    pipe_stage #(.W(37)) u_stage1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_in_valid),
        .in_ready_o  (s1_ready),
        .in_data_i   (s1_in_data),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .out_data_o  (s1_data)
    );

    assign s1_m1   = s1_data[36:25];
    assign s1_m2   = s1_data[24:13];
    assign s1_m3   = s1_data[12:1];
    assign s1_last = s1_data[0];

    // ---------------------------------------------------------------- adder
    // mode_q is stable for the whole frame and the pipeline is empty when it
    // changes, so stage 2 can use it directly instead of carrying a tag.
    assign sum_d  = s1_m1 + s1_m2 + s1_m3 + ROUND_C;
    assign gray_d = 4'(sum_d >> 6);
    assign res_d  = mode_q ? {gray_d, gray_d, gray_d} : s1_m1;

    assign s2_in_data = {res_d, s1_last};

    pipe_stage #(.W(13)) u_stage2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .in_data_i   (s2_in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s2_data)
    );

    assign out_rgb  = s2_data[12:1];
    assign out_last = s2_data[0];
    assign out_fire = out_valid && out_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = gray_en;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (in_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_is_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // start is not looked at here, so a start on the exit cycle is dropped.
                if (out_fire && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: doc/gray_pipe_ctrl.md
GRAY_PIPE_CTRL -- requirements
Module: gray_pipe_ctrl

Interface
REQ-001 The block SHALL have parameter PIX_COUNT, default 76800, meaning the number of pixels per frame (320x240).
REQ-002 The block SHALL have parameter CNT_W, default 17, meaning the pixel counter width; PIX_COUNT SHALL be no greater than 2^CNT_W-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset; synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: frame start pulse; honoured only in IDLE.
REQ-006 The block SHALL have port gray_en, input, 1 bit: mode select, sampled when start is accepted; 1 = grayscale, 0 = pass-through.
REQ-007 The block SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_rgb (input, 12 bits, {r[3:0],g[3:0],b[3:0]}): the input pixel stream.
REQ-008 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_rgb (output, 12 bits) and out_last (output, 1 bit, marks the final pixel of the frame): the output pixel stream.
REQ-009 The block SHALL have ports busy (output, 1 bit, high outside IDLE) and done (output, 1 bit, one-cycle pulse at frame completion).

Function
REQ-010 A transfer SHALL occur on a cycle where valid and ready are both high; data SHALL be held stable while valid is high and ready is low.
REQ-011 FSM states SHALL be IDLE, RUN and DRAIN. Transitions: IDLE->RUN on start; RUN->DRAIN on the PIX_COUNT-th input transfer; DRAIN->IDLE on the output transfer with out_last=1.
REQ-012 Entering RUN SHALL latch gray_en into mode_q and clear the pixel counter; start SHALL be ignored in RUN and DRAIN.
REQ-013 in_ready SHALL equal (state==RUN) AND (stage 1 empty OR stage 1 advancing).
REQ-014 The pipeline SHALL have two stages. Stage 1 registers the multiplier products m1..m3 (12 bits each), valid and last. Stage 2 registers the adder result out_rgb, out_valid and out_last.
REQ-015 A stage SHALL advance when it is empty or the downstream stage accepts; out_valid high with out_ready low SHALL stall both stages without loss or duplication.
REQ-016 Latency SHALL be 2 cycles: an input accepted at edge N appears on out_valid after edge N+2 when there is no backpressure; sustained throughput SHALL be 1 pixel per cycle.
REQ-017 Grayscale mode: each product SHALL be {2'b00,chan}*weight in 12 bits, with weights R=14, G=46 and B=5 (6-bit, /64). The sum SHALL be m1+m2+m3+32, taken modulo 2^12, with gray=sum[9:6] and out_rgb={gray,gray,gray}.
REQ-018 Pass-through mode: out_rgb SHALL equal in_rgb exactly.
REQ-019 Pixels SHALL be counted on input transfers; last SHALL be tagged on transfer number PIX_COUNT and SHALL travel with that pixel to out_last.
REQ-020 done SHALL pulse in the cycle after the out_last transfer, with the FSM in IDLE in that same cycle.
REQ-021 in_valid SHALL be ignored in IDLE and DRAIN, and no extra pixels SHALL enter the pipeline.
REQ-022 start coinciding with the final output transfer (DRAIN exit) SHALL be ignored; start SHALL be accepted only while already in IDLE.

Reset
REQ-023 On rst=1 at a clock edge, state SHALL become IDLE, and the counter, mode_q, both stage valids, out_valid, out_last, busy, done and in_ready SHALL become 0. out_rgb SHALL become 12'h000.
REQ-024 Reset mid-frame SHALL discard in-flight pixels without asserting done; rst SHALL take priority over start.

Structure
REQ-025 The weights (14, 46, 5), the rounding constant (32) and the FSM state encoding SHALL reside in the shared package gray_pkg.
REQ-026 Multiplier and adder arithmetic SHALL be computed inside this block, equivalent to REQ-017/018; one sub-module, pipe_stage (a parameterised-width valid/ready register slice), SHALL be instantiated twice.

Verification
REQ-027 Scenario: gray_en=1, in_rgb=12'hFFF -> out_rgb=12'hFFF (sum 1007).
REQ-028 Scenario: gray_en=1, in_rgb=12'h842 -> out_rgb=12'h555 (sum 338), appearing 2 cycles after acceptance.
REQ-029 Scenario: gray_en=0, in_rgb=12'h842 -> out_rgb=12'h842 (pass-through).
REQ-030 Scenario: PIX_COUNT=4, continuous stream, out_ready toggling 1010 -> exactly 4 outputs in order, out_last on the 4th, done 1 cycle later, in_ready low after the 4th input.
REQ-031 Scenario: rst asserted in RUN with 2 pixels in flight -> next cycle busy=0, out_valid=0 and no done; a fresh start then produces a full frame.
REQ-032 Scenario: start pulses during RUN and on the DRAIN exit cycle -> ignored; gray_en changed mid-frame -> no effect until the next start.
